// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between Icache refills, Dcache refills and Dcache writebacks,
// with a bounded starvation guarantee for the Icache.
module mem_arbiter #(
  parameter int WIDTH      = 128,
  parameter int ADDR_SIZE  = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ic_mem_read_req,
  input  logic [ADDR_SIZE-1:0] ic_mem_read_addr,
  output logic [WIDTH-1:0]     ic_mem_read_data,
  output logic                 ic_mem_read_ack,
  input  logic                 dc_mem_read_req,
  input  logic [ADDR_SIZE-1:0] dc_mem_read_addr,
  output logic [WIDTH-1:0]     dc_mem_read_data,
  output logic                 dc_mem_read_ack,
  input  logic                 dc_mem_write_req,
  input  logic [ADDR_SIZE-1:0] dc_mem_write_addr,
  input  logic [WIDTH-1:0]     dc_mem_write_data,
  output logic                 dc_mem_write_ack,
  output logic                 mem_enable,
  output logic                 mem_rw,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_data_in,
  input  logic [WIDTH-1:0]     mem_data_out,
  input  logic                 mem_ack
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] IC_RD   = 3'd1;
  localparam logic [2:0] DC_RD   = 3'd2;
  localparam logic [2:0] DC_WR   = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;
  localparam int CW = $clog2(STARVE_MAX + 2);
  logic [2:0]    state;
  logic [CW-1:0] starve;
  logic          ic_win;
  logic [CW-1:0] starve_dc;
  // Icache wins when it is alone or once the Dcache has used up its run of consecutive grants
  always_comb begin
    ic_win    = ic_mem_read_req && (starve == CW'(STARVE_MAX) || !(dc_mem_write_req || dc_mem_read_req));
    starve_dc = ic_mem_read_req ? starve + CW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      starve           <= '0;
      mem_enable       <= 1'b0;
      mem_rw           <= 1'b0;
      mem_addr         <= '0;
      mem_data_in      <= '0;
      ic_mem_read_ack  <= 1'b0;
      dc_mem_read_ack  <= 1'b0;
      dc_mem_write_ack <= 1'b0;
      ic_mem_read_data <= '0;
      dc_mem_read_data <= '0;
    end else begin
      ic_mem_read_ack  <= 1'b0;
      dc_mem_read_ack  <= 1'b0;
      dc_mem_write_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (ic_win) begin
            state      <= IC_RD;
            mem_enable <= 1'b1;
            mem_rw     <= 1'b0;
            mem_addr   <= ic_mem_read_addr;
            starve     <= '0;
          end else if (dc_mem_write_req) begin
            state       <= DC_WR;
            mem_enable  <= 1'b1;
            mem_rw      <= 1'b1;
            mem_addr    <= dc_mem_write_addr;
            mem_data_in <= dc_mem_write_data;
            starve      <= starve_dc;
          end else if (dc_mem_read_req) begin
            state      <= DC_RD;
            mem_enable <= 1'b1;
            mem_rw     <= 1'b0;
            mem_addr   <= dc_mem_read_addr;
            starve     <= starve_dc;
          end
        end
        IC_RD, DC_RD, DC_WR: begin
          if (mem_ack) begin
            state      <= RELEASE;
            mem_enable <= 1'b0;
            mem_rw     <= 1'b0;
            if (state == IC_RD) begin
              ic_mem_read_data <= mem_data_out;
              ic_mem_read_ack  <= 1'b1;
            end
            if (state == DC_RD) begin
              dc_mem_read_data <= mem_data_out;
              dc_mem_read_ack  <= 1'b1;
            end
            if (state == DC_WR) dc_mem_write_ack <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
